hist_req_arbiter: RTL and testbench
===================================

HIST_REQ_ARBITER -- requirements
Module: hist_req_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of sample requesters (2..8).
REQ-002 SHALL have parameter BIN_W, default 6, meaning bin-index width (64 bins).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port enable, input, 1, meaning level; permits the block to accept samples.
REQ-006 SHALL have port flush_req, input, 1, meaning single-cycle pulse; requests drain of all held samples.
REQ-007 SHALL have port in_valid, input, NREQ, meaning per-requester sample valid.
REQ-008 SHALL have port in_bin, input, NREQ*BIN_W, meaning per-requester bin index; requester i occupies bits [i*BIN_W +: BIN_W].
REQ-009 SHALL have port in_ready, output, NREQ, meaning per-requester accept.
REQ-010 SHALL have port hist_ready, input, 1, meaning the histogram core can take a write this cycle (low while it dumps or resets bins).
REQ-011 SHALL have port hist_wr_en, output, 1, meaning registered single-cycle bin-increment strobe.
REQ-012 SHALL have port hist_bin, output, BIN_W, meaning registered bin index qualified by hist_wr_en.
REQ-013 SHALL have port flush_done, output, 1, meaning registered single-cycle pulse; drain complete.
REQ-014 SHALL have port busy, output, 1, meaning state != IDLE or any holding register full.
REQ-015 SHALL have port grant_cnt, output, 16, meaning saturating count of issued hist_wr_en strobes.

Function
REQ-016 SHALL keep one holding register per requester: hold_vld[i], hold_bin[i].
REQ-017 SHALL drive in_ready[i] = ~hold_vld[i] AND (state == RUN); it is a function of registered state only.
REQ-018 SHALL capture a sample when in_valid[i] AND in_ready[i]: hold_vld[i] <= 1, hold_bin[i] <= in_bin slice; a sample offered while in_ready[i] = 0 is not captured and remains the requester's to hold.
REQ-019 SHALL arbitrate in every state, once per cycle, only when hist_ready = 1 and at least one hold_vld is set.
REQ-020 SHALL grant round-robin: the winner is the first i with hold_vld[i] = 1, searching from rr_ptr upward modulo NREQ.
REQ-021 SHALL, on grant g: hist_wr_en <= 1, hist_bin <= hold_bin[g], hold_vld[g] <= 0, rr_ptr <= (g+1) mod NREQ; latency from capture to strobe is at least 1 cycle.
REQ-022 SHALL, with no grant in a cycle, drive hist_wr_en <= 0 and leave hist_bin, rr_ptr and all holding registers unchanged.
REQ-023 SHALL never capture into and grant from the same holding register in one cycle; refill earliest the cycle after it is cleared.
REQ-024 SHALL increment grant_cnt on each grant and saturate at 16'hFFFF.
REQ-025 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-026 SHALL transition IDLE -> RUN when enable = 1 and flush_req = 0.
REQ-027 SHALL transition RUN -> DRAIN on flush_req = 1, which takes priority over enable = 0.
REQ-028 SHALL transition RUN -> IDLE on enable = 0 with no flush_req; held samples still drain.
REQ-029 SHALL, in DRAIN, when all hold_vld = 0 and hist_wr_en = 0, pulse flush_done for one cycle and go to IDLE.
REQ-030 SHALL, on flush_req in IDLE, go to DRAIN; with empty holds flush_done pulses the following cycle.
REQ-031 SHALL ignore flush_req in DRAIN, and SHALL ignore enable in DRAIN.
REQ-032 SHALL leave in_valid on a requester with no holding space without effect; no sample is ever duplicated or lost once captured.

Reset
REQ-033 SHALL, on rst_n low at any time including mid-drain, immediately force: state = IDLE, all hold_vld = 0, rr_ptr = 0, hist_wr_en = 0, hist_bin = 0, flush_done = 0, grant_cnt = 0, in_ready = 0, busy = 0.
REQ-034 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-035 SHALL cover single sample: enable = 1, requester 2 offers bin 5 with hist_ready = 1 -> hist_wr_en for 1 cycle with hist_bin = 5 two cycles after the offer; grant_cnt = 1.
REQ-036 SHALL cover fairness: all 4 requesters hold samples with rr_ptr = 0 -> grants in order 0, 1, 2, 3 on consecutive cycles, then rr_ptr = 0.
REQ-037 SHALL cover back-pressure: hist_ready = 0 for 10 cycles with 4 held samples -> no strobes and in_ready = 0000; hist_ready = 1 -> 4 strobes, none lost.
REQ-038 SHALL cover flush: flush_req in RUN with 3 held samples -> in_ready = 0 from the next cycle, 3 strobes, then a single flush_done pulse, then state IDLE.
REQ-039 SHALL cover asynchronous reset: rst_n low mid-DRAIN with samples held -> all outputs 0 without a clock edge; no flush_done issued.
REQ-040 SHALL cover saturation: grant_cnt preloaded by 65535 grants, then one more grant -> grant_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/hist_req_arbiter.sv
// hist_req_arbiter: collects bin-index samples from NREQ requesters into
// single-entry holding registers and forwards them one per cycle, in
// round-robin order, as increment strobes to a histogram core.
module hist_req_arbiter #(
  parameter int NREQ  = 4,
  parameter int BIN_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  flush_req,
  input  logic [NREQ-1:0]       in_valid,
  input  logic [NREQ*BIN_W-1:0] in_bin,
  output logic [NREQ-1:0]       in_ready,
  input  logic                  hist_ready,
  output logic                  hist_wr_en,
  output logic [BIN_W-1:0]      hist_bin,
  output logic                  flush_done,
  output logic                  busy,
  output logic [15:0]           grant_cnt
);

  localparam int          PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREQ_U = NREQ;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             flush_done_nxt;

  logic [NREQ-1:0]  hold_vld;
  logic [BIN_W-1:0] hold_bin [NREQ];
  logic [PTR_W-1:0] rr_ptr;

  logic             gnt_any;
  logic [PTR_W-1:0] gnt_idx;
  logic [NREQ-1:0]  gnt_oh;
  logic [PTR_W-1:0] ptr_nxt;
  logic [NREQ-1:0]  capture;
  int unsigned      scan;

  // Acceptance depends only on registered state, so a holder being granted
  // this cycle (hold_vld still 1) can never be refilled in the same cycle.
  assign in_ready = ~hold_vld & {NREQ{state == RUN}};
  assign capture  = in_valid & in_ready;
  assign busy     = (state != IDLE) | (|hold_vld);

  // Round-robin winner: first full holder at or above rr_ptr, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    ptr_nxt = rr_ptr;
    scan    = 0;
    if (hist_ready) begin
      for (int unsigned k = 0; k < NREQ_U; k++) begin
        scan = (32'(rr_ptr) + k) % NREQ_U;
        if (!gnt_any && hold_vld[PTR_W'(scan)]) begin
          gnt_any = 1'b1;
          gnt_idx = PTR_W'(scan);
        end
      end
      if (gnt_any) begin
        gnt_oh[gnt_idx] = 1'b1;
        ptr_nxt         = PTR_W'((32'(gnt_idx) + 1) % NREQ_U);
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; drain completes once holds are empty and the last
  // strobe has already left.
  always_comb begin
    state_nxt      = state;
    flush_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (flush_req)   state_nxt = DRAIN;
        else if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (flush_req)    state_nxt = DRAIN;
        else if (!enable) state_nxt = IDLE;
      end
      DRAIN: begin
        if ((hold_vld == '0) && !hist_wr_en) begin
          flush_done_nxt = 1'b1;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Holding-register occupancy, grant strobe, pointer and grant counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld   <= '0;
      rr_ptr     <= '0;
      hist_wr_en <= 1'b0;
      hist_bin   <= '0;
      flush_done <= 1'b0;
      grant_cnt  <= '0;
    end else begin
      hist_wr_en <= gnt_any;
      flush_done <= flush_done_nxt;
      hold_vld   <= (hold_vld & ~gnt_oh) | capture;
      if (gnt_any) begin
        hist_bin <= hold_bin[gnt_idx];
        rr_ptr   <= ptr_nxt;
        if (grant_cnt != '1) grant_cnt <= grant_cnt + 16'd1;
      end
    end
  end

  // Holding-register payload; only meaningful while hold_vld is set.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      if (capture[i]) hold_bin[i] <= in_bin[i*BIN_W +: BIN_W];
    end
  end

endmodule

// File: tb/tb_hist_req_arbiter.sv
// tb_hist_req_arbiter: directed and random stimulus against a cycle-level
// behavioural model of the arbiter's externally visible rules.
module tb_hist_req_arbiter;

  localparam int NREQ  = 4;
  localparam int BIN_W = 6;

  logic                  clk        = 1'b0;
  logic                  rst_n      = 1'b1;
  logic                  enable     = 1'b0;
  logic                  flush_req  = 1'b0;
  logic                  hist_ready = 1'b0;
  logic [NREQ-1:0]       in_valid   = '0;
  logic [NREQ*BIN_W-1:0] in_bin     = '0;
  logic [NREQ-1:0]       in_ready;
  logic                  hist_wr_en;
  logic [BIN_W-1:0]      hist_bin;
  logic                  flush_done;
  logic                  busy;
  logic [15:0]           grant_cnt;

  hist_req_arbiter #(.NREQ(NREQ), .BIN_W(BIN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .flush_req  (flush_req),
    .in_valid   (in_valid),
    .in_bin     (in_bin),
    .in_ready   (in_ready),
    .hist_ready (hist_ready),
    .hist_wr_en (hist_wr_en),
    .hist_bin   (hist_bin),
    .flush_done (flush_done),
    .busy       (busy),
    .grant_cnt  (grant_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Behavioural model
  typedef enum {M_IDLE, M_RUN, M_DRAIN} mmode_t;
  mmode_t           m_mode;
  bit               m_full [NREQ];
  logic [BIN_W-1:0] m_bin  [NREQ];
  int               m_ptr;
  bit               m_wr;
  logic [BIN_W-1:0] m_hbin;
  bit               m_fd;
  int               m_cnt;
  int               m_caps;
  int               dut_strobes;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [NREQ-1:0] m_rdy();
    logic [NREQ-1:0] r = '0;
    for (int i = 0; i < NREQ; i++) r[i] = !m_full[i] && (m_mode == M_RUN);
    return r;
  endfunction

  function automatic bit m_any();
    bit a = 0;
    for (int i = 0; i < NREQ; i++) a |= m_full[i];
    return a;
  endfunction

  task automatic m_reset();
    m_mode = M_IDLE;
    for (int i = 0; i < NREQ; i++) begin
      m_full[i] = 0;
      m_bin[i]  = '0;
    end
    m_ptr = 0; m_wr = 0; m_hbin = '0; m_fd = 0; m_cnt = 0;
    m_caps = 0; dut_strobes = 0;
  endtask

  task automatic m_step();
    logic [NREQ-1:0] rdy     = m_rdy();
    bit              empty   = !m_any();
    bit              wr_prev = m_wr;
    int              g       = -1;
    if (hist_ready) begin
      for (int k = 0; k < NREQ; k++) begin
        int j = (m_ptr + k) % NREQ;
        if (g < 0 && m_full[j]) g = j;
      end
    end
    m_wr = (g >= 0);
    m_fd = 0;
    if (g >= 0) begin
      m_hbin    = m_bin[g];
      m_full[g] = 0;
      m_ptr     = (g + 1) % NREQ;
      if (m_cnt < 65535) m_cnt++;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (in_valid[i] && rdy[i]) begin
        m_full[i] = 1;
        m_bin[i]  = in_bin[i*BIN_W +: BIN_W];
        m_caps++;
      end
    end
    case (m_mode)
      M_IDLE:  if (flush_req) m_mode = M_DRAIN; else if (enable) m_mode = M_RUN;
      M_RUN:   if (flush_req) m_mode = M_DRAIN; else if (!enable) m_mode = M_IDLE;
      M_DRAIN: if (empty && !wr_prev) begin m_fd = 1; m_mode = M_IDLE; end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check pre-edge outputs, advance model, check post-edge.
  task automatic tick();
    check("in_ready", 32'(in_ready), 32'(m_rdy()));
    check("busy", 32'(busy), 32'(m_mode != M_IDLE || m_any()));
    m_step();
    @(posedge clk);
    #1;
    if (hist_wr_en) dut_strobes++;
    check("hist_wr_en", 32'(hist_wr_en), 32'(m_wr));
    check("hist_bin", 32'(hist_bin), 32'(m_hbin));
    check("flush_done", 32'(flush_done), 32'(m_fd));
    check("grant_cnt", 32'(grant_cnt), m_cnt);
  endtask

  task automatic offer(input int i, input logic [BIN_W-1:0] b);
    in_valid[i]            = 1'b1;
    in_bin[i*BIN_W +: BIN_W] = b;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr"},    32'(hist_wr_en), 0);
    check({tag, "_bin"},   32'(hist_bin),   0);
    check({tag, "_fd"},    32'(flush_done), 0);
    check({tag, "_cnt"},   32'(grant_cnt),  0);
    check({tag, "_rdy"},   32'(in_ready),   0);
    check({tag, "_busy"},  32'(busy),       0);
  endtask

  initial begin
    int s0, fd_n;
    m_reset();

    // Reset state
    #1 rst_n = 1'b0;
    #2 check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single sample: requester 2, bin 5
    enable = 1'b1; hist_ready = 1'b1;
    tick();
    offer(2, 6'd5); tick(); in_valid = '0;
    tick();
    check("single_wr", 32'(hist_wr_en), 1);
    check("single_bin", 32'(hist_bin), 5);
    check("single_cnt", 32'(grant_cnt), 1);
    tick();
    check("single_pulse", 32'(hist_wr_en), 0);

    // Grant requester 3 so the pointer wraps back to 0
    offer(3, 6'd7); tick(); in_valid = '0;
    tick(); tick();

    // Back-pressure with four held samples, then round-robin release
    hist_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) offer(i, 6'(10 + i));
    tick(); in_valid = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("bp_ready", 32'(in_ready), 0);
      check("bp_wr", 32'(hist_wr_en), 0);
    end
    hist_ready = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      tick();
      check("rr_wr", 32'(hist_wr_en), 1);
      check("rr_order", 32'(hist_bin), 10 + k);
    end
    tick();
    check("rr_done", 32'(hist_wr_en), 0);

    // Pointer back at 0: requesters 3 and 1 pending -> 1 first, then 3
    hist_ready = 1'b0;
    offer(3, 6'd20); offer(1, 6'd21); tick(); in_valid = '0;
    hist_ready = 1'b1;
    tick(); check("ptr_first", 32'(hist_bin), 21);
    tick(); check("ptr_second", 32'(hist_bin), 20);
    tick();

    // Flush in RUN with three held samples; flush wins over enable low
    hist_ready = 1'b0;
    offer(0, 6'd30); offer(1, 6'd31); offer(3, 6'd33); tick(); in_valid = '0;
    s0 = dut_strobes; fd_n = 0;
    flush_req = 1'b1; enable = 1'b0; hist_ready = 1'b1;
    tick(); flush_req = 1'b0;
    if (flush_done) fd_n++;
    check("flush_rdy", 32'(in_ready), 0);
    for (int c = 0; c < 12; c++) begin
      tick();
      if (flush_done) fd_n++;
    end
    check("flush_strobes", dut_strobes - s0, 3);
    check("flush_pulses", fd_n, 1);
    check("flush_idle", 32'(busy), 0);

    // Flush in IDLE with empty holds
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    tick();
    check("idle_flush_fd", 32'(flush_done), 1);
    tick();
    check("idle_flush_once", 32'(flush_done), 0);

    // Asynchronous reset mid-drain with samples held
    enable = 1'b1; tick();
    hist_ready = 1'b0;
    offer(0, 6'd40); offer(2, 6'd42); tick(); in_valid = '0;
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    tick();
    check("pre_rst_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1; enable = 1'b0; hist_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      enable     = ($urandom_range(0, 9) != 0);
      flush_req  = ($urandom_range(0, 29) == 0);
      hist_ready = ($urandom_range(0, 3) != 0);
      in_valid   = NREQ'($urandom);
      in_bin     = (NREQ*BIN_W)'($urandom);
      tick();
    end
    enable = 1'b0; flush_req = 1'b0; in_valid = '0; hist_ready = 1'b1;
    for (int c = 0; c < 12; c++) tick();
    check("conserve", dut_strobes, m_caps);

    // Saturation of the grant counter
    enable = 1'b1; in_valid = '1; in_bin = (NREQ*BIN_W)'($urandom);
    for (int c = 0; c < 70000 && m_cnt < 65535; c++) tick();
    check("sat_reach", 32'(grant_cnt), 32'hFFFF);
    for (int c = 0; c < 3; c++) tick();
    check("sat_strobe", 32'(hist_wr_en), 1);
    check("sat_hold", 32'(grant_cnt), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Time limit guard
  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule
